// File: rtl/car_motion_controller.sv
// Elevator car motion controller for a 7-floor car.
// Consumes the direction director's decision each cycle, runs the per-floor
// travel timer and the door timer, tracks the car floor, and pulses clears
// back to the request latches for every call it serves. All outputs are
// registered.
module car_motion_controller #(
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  nextDirection,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  currentDirection,
    output logic        doorState,
    output logic        move,
    output logic [13:0] clearFloor,
    output logic [7:1]  clearInternal
);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b01;

    localparam int TW = (FLOOR_TICKS > 2) ? $clog2(FLOOR_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 2) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(FLOOR_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN,
        SETTLE
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     floor_q, floor_d;
    logic [1:0]     dir_q, dir_d;
    logic           door_q, door_d;
    logic           move_q, move_d;
    logic [13:0]    clr_floor_q, clr_floor_d;
    logic [6:0]     clr_int_q, clr_int_d;
    logic [TW-1:0]  travel_q, travel_d;
    logic [DW-1:0]  door_cnt_q, door_cnt_d;

    // Per-floor request views, bit index = floor-1.
    logic [6:0] car_v, up_v, dn_v, calls_v;
    logic [6:0] clr_up_v, clr_dn_v;
    logic [6:0] car_new, up_new, dn_new;
    logic [2:0] here_idx, next_floor, next_idx;
    logic       here_any, at_end;
    logic [3:0] srv_here, srv_next;

    assign car_v   = internalButton[7:1];
    assign up_v    = {floorButton[13], floorButton[11], floorButton[9], floorButton[7],
                      floorButton[5], floorButton[3], floorButton[1]};
    assign dn_v    = {floorButton[12], floorButton[10], floorButton[8], floorButton[6],
                      floorButton[4], floorButton[2], floorButton[0]};
    assign calls_v = car_v | up_v | dn_v;

    // A request still visible while its own clear pulse is out is not new;
    // the latch drops it on the same edge that samples the pulse.
    assign clr_up_v = {clr_floor_q[13], clr_floor_q[11], clr_floor_q[9], clr_floor_q[7],
                       clr_floor_q[5], clr_floor_q[3], clr_floor_q[1]};
    assign clr_dn_v = {clr_floor_q[12], clr_floor_q[10], clr_floor_q[8], clr_floor_q[6],
                       clr_floor_q[4], clr_floor_q[2], clr_floor_q[0]};
    assign car_new  = car_v & ~clr_int_q;
    assign up_new   = up_v & ~clr_up_v;
    assign dn_new   = dn_v & ~clr_dn_v;

    assign here_idx   = floor_q - 3'd1;
    assign next_floor = (dir_q == DIR_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
    assign next_idx   = next_floor - 3'd1;
    assign here_any   = car_v[here_idx] | up_v[here_idx] | dn_v[here_idx];
    assign at_end     = ((dir_q == DIR_UP) && (next_floor == 3'd7)) ||
                        ((dir_q == DIR_DOWN) && (next_floor == 3'd1));

    // Which calls at floor f are served when the car is there heading dir.
    // Returns {drop_direction, car, hall_up, hall_down}. With nothing beyond
    // the floor in the travel direction (or no direction) both hall calls are
    // taken and the car gives up its direction.
    function automatic logic [3:0] serve_at(
        input logic [2:0] f,
        input logic [1:0] dir,
        input logic [6:0] calls,
        input logic [6:0] car,
        input logic [6:0] up,
        input logic [6:0] dn
    );
        logic [2:0] idx;
        logic       b_up, b_dn, beyond, both;
        idx    = f - 3'd1;
        b_up   = |(calls >> f);
        b_dn   = |(calls << (4'd8 - {1'b0, f}));
        beyond = (dir == DIR_UP) ? b_up : ((dir == DIR_DOWN) ? b_dn : 1'b0);
        both   = !beyond;
        serve_at = {both, car[idx],
                    up[idx] & ((dir == DIR_UP) | both),
                    dn[idx] & ((dir == DIR_DOWN) | both)};
    endfunction

    assign srv_here = serve_at(floor_q, dir_q, calls_v, car_new, up_new, dn_new);
    assign srv_next = serve_at(next_floor, dir_q, calls_v, car_v, up_v, dn_v);

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            floor_q     <= 3'd1;
            dir_q       <= DIR_STOP;
            door_q      <= 1'b0;
            move_q      <= 1'b0;
            clr_floor_q <= '0;
            clr_int_q   <= '0;
            travel_q    <= '0;
            door_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            door_q      <= door_d;
            move_q      <= move_d;
            clr_floor_q <= clr_floor_d;
            clr_int_q   <= clr_int_d;
            travel_q    <= travel_d;
            door_cnt_q  <= door_cnt_d;
        end
    end

    // Next-state and next-output logic; clears default to zero so every
    // pulse lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        door_d      = door_q;
        move_d      = move_q;
        clr_floor_d = '0;
        clr_int_d   = '0;
        travel_d    = travel_q;
        door_cnt_d  = door_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (here_any || internalButton[8]) begin
                    state_d     = DOOR_OPEN;
                    door_d      = 1'b1;
                    door_cnt_d  = DOOR_LOAD;
                    clr_int_d   = {6'b0, srv_here[2]} << here_idx;
                    clr_floor_d = {12'b0, srv_here[1], srv_here[0]} << {here_idx, 1'b0};
                    if (srv_here[3]) dir_d = DIR_STOP;
                end else if (((nextDirection == DIR_UP) && (floor_q < 3'd7)) ||
                             ((nextDirection == DIR_DOWN) && (floor_q > 3'd1))) begin
                    state_d  = MOVING;
                    dir_d    = nextDirection;
                    move_d   = 1'b1;
                    travel_d = TRAVEL_LOAD;
                end else begin
                    dir_d = DIR_STOP;
                end
            end
            MOVING: begin
                if (travel_q != '0) begin
                    travel_d = travel_q - 1'b1;
                end else begin
                    floor_d = next_floor;
                    if ((|srv_next[2:0]) || at_end) begin
                        state_d     = DOOR_OPEN;
                        move_d      = 1'b0;
                        door_d      = 1'b1;
                        door_cnt_d  = DOOR_LOAD;
                        clr_int_d   = {6'b0, srv_next[2]} << next_idx;
                        clr_floor_d = {12'b0, srv_next[1], srv_next[0]} << {next_idx, 1'b0};
                        if (srv_next[3]) dir_d = DIR_STOP;
                    end else begin
                        travel_d = TRAVEL_LOAD;
                    end
                end
            end
            DOOR_OPEN: begin
                if (|srv_here[2:0]) begin
                    door_cnt_d  = DOOR_LOAD;
                    clr_int_d   = {6'b0, srv_here[2]} << here_idx;
                    clr_floor_d = {12'b0, srv_here[1], srv_here[0]} << {here_idx, 1'b0};
                    if (srv_here[3]) dir_d = DIR_STOP;
                end else if (internalButton[8]) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (internalButton[9] || (door_cnt_q == '0)) begin
                    door_d  = 1'b0;
                    state_d = SETTLE;
                end else begin
                    door_cnt_d = door_cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign currentFloor     = floor_q;
    assign currentDirection = dir_q;
    assign doorState        = door_q;
    assign move             = move_q;
    assign clearFloor       = clr_floor_q;
    assign clearInternal    = clr_int_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Directed bench for car_motion_controller. A small request latch model
// (set by button presses, dropped by the DUT clear pulses) feeds the DUT
// the way the real hall/car latches would.
module tb_car_motion_controller;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] DOWN = 2'b01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  nd = STOP;
    logic [13:0] hall_q;
    logic [7:1]  car_q;
    logic [13:0] hall_set = '0;
    logic [7:1]  car_set = '0;
    logic        ib8 = 1'b0;
    logic        ib9 = 1'b0;
    logic [9:1]  internal_button;
    logic [2:0]  current_floor;
    logic [1:0]  current_direction;
    logic        door_state;
    logic        move;
    logic [13:0] clear_floor;
    logic [7:1]  clear_internal;
    int          checks = 0;
    int          errors = 0;

    assign internal_button = {ib9, ib8, car_q};

    car_motion_controller #(.FLOOR_TICKS(8), .DOOR_TICKS(6)) dut (
        .clk(clk),
        .reset(reset),
        .nextDirection(nd),
        .floorButton(hall_q),
        .internalButton(internal_button),
        .currentFloor(current_floor),
        .currentDirection(current_direction),
        .doorState(door_state),
        .move(move),
        .clearFloor(clear_floor),
        .clearInternal(clear_internal)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Request latches: presses set bits, DUT clear pulses drop them.
    always @(posedge clk) begin
        if (reset) begin
            hall_q <= '0;
            car_q  <= '0;
        end else begin
            hall_q <= (hall_q | hall_set) & ~clear_floor;
            car_q  <= (car_q | car_set) & ~clear_internal;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_floor"}, 16'(current_floor), 16'd1);
        check({tag, "_dir"}, 16'(current_direction), 16'(STOP));
        check({tag, "_door"}, 16'(door_state), 16'd0);
        check({tag, "_move"}, 16'(move), 16'd0);
        check({tag, "_clrf"}, 16'(clear_floor), 16'd0);
        check({tag, "_clri"}, 16'(clear_internal), 16'd0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick(2);
        check_reset_state("reset");
        reset = 1'b0;
        tick(1);

        // Car call to floor 4 from floor 1
        car_set = 7'b0001000;
        tick(1);
        car_set = '0;
        nd = UP;
        tick(1);
        check("t1_move_start", 16'(move), 16'd1);
        check("t1_dir_up", 16'(current_direction), 16'(UP));
        tick(7);
        check("t1_floor1_hold", 16'(current_floor), 16'd1);
        tick(1);
        check("t1_floor2", 16'(current_floor), 16'd2);
        tick(8);
        check("t1_floor3", 16'(current_floor), 16'd3);
        tick(8);
        check("t1_floor4", 16'(current_floor), 16'd4);
        check("t1_stop_move", 16'(move), 16'd0);
        check("t1_door_open", 16'(door_state), 16'd1);
        check("t1_clr_int4", 16'(clear_internal), 16'h0008);
        check("t1_dir_stop", 16'(current_direction), 16'(STOP));
        nd = STOP;
        tick(1);
        check("t1_clr_once", 16'(clear_internal), 16'd0);
        tick(4);
        check("t1_door_last", 16'(door_state), 16'd1);
        nd = DOWN;
        tick(1);
        check("t1_door_closed", 16'(door_state), 16'd0);
        check("t1_settle_move", 16'(move), 16'd0);
        tick(1);
        check("t1_idle_move", 16'(move), 16'd0);
        tick(1);
        check("t1_move_down", 16'(move), 16'd1);
        check("t1_dir_down", 16'(current_direction), 16'(DOWN));
        tick(24);
        check("t1_floor1_end", 16'(current_floor), 16'd1);
        check("t1_door_f1", 16'(door_state), 16'd1);
        check("t1_dir_f1", 16'(current_direction), 16'(STOP));
        check("t1_clrf_f1", 16'(clear_floor), 16'd0);
        nd = STOP;
        tick(7);

        // Hall UP at 3 and hall DOWN at 5 while heading up
        hall_set = 14'h0120;
        tick(1);
        hall_set = '0;
        nd = UP;
        tick(1);
        check("t2_move_start", 16'(move), 16'd1);
        tick(16);
        check("t2_floor3", 16'(current_floor), 16'd3);
        check("t2_door3", 16'(door_state), 16'd1);
        check("t2_clrf3", 16'(clear_floor), 16'h0020);
        check("t2_dir3_up", 16'(current_direction), 16'(UP));
        tick(1);
        check("t2_clrf3_once", 16'(clear_floor), 16'd0);
        tick(5);
        check("t2_door3_closed", 16'(door_state), 16'd0);
        tick(1);
        check("t2_settle_move", 16'(move), 16'd0);
        tick(1);
        check("t2_move_again", 16'(move), 16'd1);
        tick(16);
        check("t2_floor5", 16'(current_floor), 16'd5);
        check("t2_door5", 16'(door_state), 16'd1);
        check("t2_clrf5", 16'(clear_floor), 16'h0100);
        check("t2_dir5_stop", 16'(current_direction), 16'(STOP));

        // Travel to floor 7 and sit there with UP requested
        tick(8);
        check("t3_move_start", 16'(move), 16'd1);
        tick(16);
        check("t3_floor7", 16'(current_floor), 16'd7);
        check("t3_door7", 16'(door_state), 16'd1);
        check("t3_dir7_stop", 16'(current_direction), 16'(STOP));
        for (int i = 0; i < 24; i++) begin
            tick(1);
            check("t3_no_move", 16'(move), 16'd0);
            check("t3_floor_hold", 16'(current_floor), 16'd7);
        end
        check("t3_door_closed", 16'(door_state), 16'd0);

        // Door buttons at floor 2
        reset = 1'b1;
        nd = STOP;
        tick(1);
        check_reset_state("t4_reset");
        reset = 1'b0;
        car_set = 7'b0000010;
        tick(1);
        car_set = '0;
        nd = UP;
        tick(1);
        check("t4_move_start", 16'(move), 16'd1);
        tick(8);
        check("t4_floor2", 16'(current_floor), 16'd2);
        check("t4_door2", 16'(door_state), 16'd1);
        check("t4_clr_int2", 16'(clear_internal), 16'h0002);
        nd = STOP;
        tick(3);
        ib8 = 1'b1;
        tick(1);
        ib8 = 1'b0;
        tick(5);
        check("t4_open_held", 16'(door_state), 16'd1);
        tick(1);
        check("t4_open_expired", 16'(door_state), 16'd0);
        tick(1);
        ib8 = 1'b1;
        tick(1);
        check("t4_reopen", 16'(door_state), 16'd1);
        check("t4_reopen_clri", 16'(clear_internal), 16'd0);
        check("t4_reopen_clrf", 16'(clear_floor), 16'd0);
        ib8 = 1'b0;
        tick(1);
        ib9 = 1'b1;
        tick(1);
        check("t4_close_btn", 16'(door_state), 16'd0);
        ib9 = 1'b0;
        tick(1);
        ib8 = 1'b1;
        tick(1);
        check("t4_reopen2", 16'(door_state), 16'd1);
        ib9 = 1'b1;
        tick(1);
        ib8 = 1'b0;
        ib9 = 1'b0;
        tick(5);
        check("t4_both_open_wins", 16'(door_state), 16'd1);
        tick(1);
        check("t4_both_expired", 16'(door_state), 16'd0);

        // Hall call at the open floor re-pulses and restarts the door
        tick(1);
        ib8 = 1'b1;
        tick(1);
        check("t6_door_open", 16'(door_state), 16'd1);
        ib8 = 1'b0;
        tick(2);
        hall_set = 14'h0008;
        tick(1);
        hall_set = '0;
        tick(1);
        check("t6_clrf_repulse", 16'(clear_floor), 16'h0008);
        check("t6_door_still", 16'(door_state), 16'd1);
        tick(1);
        check("t6_clrf_once", 16'(clear_floor), 16'd0);
        tick(4);
        check("t6_door_restarted", 16'(door_state), 16'd1);
        tick(1);
        check("t6_door_closed", 16'(door_state), 16'd0);

        // Reset between floors 3 and 4
        tick(1);
        nd = UP;
        tick(1);
        check("t5_move_start", 16'(move), 16'd1);
        tick(8);
        check("t5_floor3", 16'(current_floor), 16'd3);
        tick(4);
        check("t5_mid_move", 16'(move), 16'd1);
        reset = 1'b1;
        tick(1);
        check_reset_state("t5_reset");
        reset = 1'b0;
        nd = DOWN;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t5_down_at1_move", 16'(move), 16'd0);
            check("t5_down_at1_floor", 16'(current_floor), 16'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_motion_controller.md
Name: car_motion_controller

Overview:
- Sequences the elevator car for the 7-floor, 2-way system.
- Each cycle it consumes the direction decision from the direction director. It runs the per-floor travel timer and the door open/close timer, and tracks the car floor.
- It drives currentFloor, currentDirection, doorState and move back to the director.
- It issues one-cycle clear pulses so the request latches drop the calls it has served.

Parameters:
FLOOR_TICKS, 8, clock cycles to travel one floor (minimum 2)
DOOR_TICKS, 6, clock cycles the door stays open without further requests (minimum 2)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
nextDirection  input  2  director decision; STOP=00, UP=10, DOWN=01; 11 is treated as STOP
floorButton  input  14  latched hall calls; floor f (1..7) uses bits [2f-1:2f-2]; upper bit = UP call, lower bit = DOWN call
internalButton  input  9  [9:1]; bits 1..7 = car calls for floors 1..7; bit 8 = door-open button; bit 9 = door-close button
currentFloor  output  3  car floor, range 1..7
currentDirection  output  2  STOP/UP/DOWN, same encoding as nextDirection
doorState  output  1  1=OPEN, 0=CLOSE
move  output  1  1=MOVE, 0=HOLD
clearFloor  output  14  one-cycle pulse per hall-call bit served, same bit layout as floorButton
clearInternal  output  7  [7:1] one-cycle pulse per car call served

Behaviour:
- Reset (synchronous, highest priority, also mid-move or mid-door):
  - state=IDLE, currentFloor=1, currentDirection=STOP, doorState=0, move=0, clears=0, timers=0.
- States: IDLE, MOVING, DOOR_OPEN, SETTLE. All outputs are registered.
- "here" at floor f: internalButton[f] is set, or floorButton pair f is nonzero.
- beyond(dir): any car or hall call strictly above currentFloor (UP) or strictly below it (DOWN).
- IDLE (move=0, door=0):
  - If here or internalButton[8]: go to DOOR_OPEN.
  - Else, if nextDirection=UP and floor<7, or nextDirection=DOWN and floor>1:
    - currentDirection<=nextDirection, move<=1, travel counter<=FLOOR_TICKS-1, go to MOVING.
  - Else: currentDirection<=STOP and stay in IDLE.
  - nextDirection=UP at floor 7 or DOWN at floor 1 is ignored.
- MOVING (move=1):
  - The counter decrements each cycle.
  - At counter==0, currentFloor increments (UP) or decrements (DOWN) by exactly 1.
  - Then evaluate the new floor n. Stop if any of:
    - internalButton[n] is set;
    - the hall bit for n matching currentDirection is set;
    - any hall bit for n is set and beyond(currentDirection)=0;
    - n==7 while going UP, or n==1 while going DOWN.
  - On stop: move<=0, go to DOOR_OPEN. Otherwise reload the counter and stay in MOVING.
  - The floor never wraps and never leaves 1..7.
- DOOR_OPEN (door=1, move=0):
  - The entry cycle loads the door timer with DOOR_TICKS-1 and asserts the clear pulses for this floor:
    - clearInternal[f];
    - the hall bit matching currentDirection;
    - if beyond(currentDirection)=0 or the direction is STOP: both hall bits, and currentDirection<=STOP.
  - A new "here" request while open re-pulses its clear and reloads the timer.
  - internalButton[8] reloads the timer.
  - internalButton[9] forces expiry on the next cycle.
  - If bits 8 and 9 are set in the same cycle, open wins.
  - On timer==0: door<=0, go to SETTLE.
- SETTLE:
  - One cycle with door=0 and move=0, so the director registers a fresh nextDirection. Then go to IDLE.
- Clear pulses are exactly 1 cycle wide and only occur in DOOR_OPEN.
- move and doorState are never 1 at the same time.

Test Plan:
- Reset, then internalButton[4]=1 at floor 1 with nextDirection=UP → move=1; currentFloor steps 2,3,4, one floor every 8 cycles; at floor 4: move=0, doorState=1, clearInternal[4] pulses 1 cycle; door closes 6 cycles later; then 1 SETTLE cycle.
- Car at floor 1 going UP, hall UP at floor 3 (floorButton[5]) and hall DOWN at floor 5 (floorButton[8]) → stops at 3 clearing only bit 5; stops at 5 clearing bit 8 with currentDirection=STOP.
- At floor 7 idle with nextDirection=UP and no calls → stays in IDLE; move never asserts; currentFloor stays 7.
- Door open at floor 2: pulse internalButton[8] at cycle 4 → door stays open 6 cycles from that point; then pulse internalButton[9] → door closes on the next cycle; bits 8 and 9 together → timer reloads.
- Assert reset during MOVING between floors 3 and 4 → next cycle currentFloor=1, move=0, doorState=0, currentDirection=STOP, clears=0.
- Hall call at the current floor arrives while the door is open → the clear re-pulses and the door timer restarts at DOOR_TICKS-1.
